bcd_converter: RTL
==================

BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 Parameter ERR_CODE, default 16'hFFFF, value driven on digit when the input exceeds 9999.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to convert bin; sampled only in IDLE.
REQ-005 bin  input  16  unsigned binary value to convert; valid range 0..9999.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  single-cycle pulse when digit is updated.
REQ-008 err  output  1  high when the last accepted bin exceeded 9999; held until the next accepted start.
REQ-009 digit  output  16  packed BCD result feeding the four-digit seven-segment scanner: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.

Function
REQ-010 The block SHALL implement states IDLE and CONV; after reset the state SHALL be IDLE.
REQ-011 In IDLE with start=1 and bin<=9999, the block SHALL latch bin into a 16-bit shift register, clear a 16-bit BCD accumulator, load iteration counter to 0, set busy=1, clear err, and enter CONV.
REQ-012 In IDLE with start=1 and bin>9999, the block SHALL set digit=ERR_CODE and err=1, and pulse done in the following cycle; it SHALL remain in IDLE and busy SHALL stay 0.
REQ-013 Each CONV cycle SHALL perform one double-dabble iteration: each accumulator nibble >=5 gets +3 (nibble-local, 4-bit, no carry between nibbles); then {accumulator, shift register} shifts left by 1.
REQ-014 The iteration counter SHALL be 5 bits and increment once per CONV cycle; exactly 16 iterations SHALL be performed.
REQ-015 On the edge performing iteration 16, the block SHALL load digit with the final accumulator, set done=1 for exactly one cycle, set busy=0, and return to IDLE.
REQ-016 Latency: done SHALL be high in the cycle following the 17th rising edge, counting the edge that samples start as edge 1; for the overflow path, done SHALL be high after edge 1.
REQ-017 start SHALL be ignored while busy=1; the in-flight conversion SHALL be unaffected, and bin changes during CONV SHALL not alter the result.
REQ-018 start held high continuously SHALL launch a new conversion on the first IDLE cycle after each done.
REQ-019 digit SHALL hold its last value between conversions and SHALL change only on a completion or overflow edge, never mid-conversion.
REQ-020 done SHALL never be high while busy=1.
REQ-021 No output SHALL depend combinationally on start or bin.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock edge, force: state=IDLE, busy=0, done=0, err=0, digit=16'h0000, shift register, accumulator and counter cleared.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion; no done pulse SHALL follow its release.
REQ-024 The first start after rst_n rises SHALL be accepted on the first rising edge at which rst_n=1.

Verification
REQ-025 Reset, then bin=16'd1234 with start high for one cycle: busy=1 for 16 cycles, then done pulse, digit=16'h1234, err=0.
REQ-026 Boundary values: bin=0 gives digit=16'h0000; bin=9999 gives digit=16'h9999; both with err=0 and identical 17-edge latency.
REQ-027 Overflow: bin=10000, start pulse: done one cycle later, digit=16'hFFFF, err=1, busy never high; then a valid start with bin=42 gives digit=16'h0042 and err=0.
REQ-028 Issue start with bin=5678, then at iteration 5 pulse start with bin=1111 and change bin: exactly one done, digit=16'h5678.
REQ-029 Assert rst_n low at iteration 8 of a conversion of bin=4321: outputs clear asynchronously, digit=16'h0000, and no done occurs after release.
REQ-030 Start held high for 100 cycles with bin=7: done pulses every 17 cycles, digit=16'h0007 each time.

Source files
------------

// File: rtl/bcd_converter.sv
// ---------------------------------------------------------------------------
// bcd_converter
//
// Converts a 16-bit unsigned binary value (0..9999) into four packed BCD
// digits using a sequential double-dabble: one shift-and-adjust iteration per
// clock, 16 iterations per conversion. Inputs above 9999 are rejected
// immediately: ERR_CODE is driven on digit and err is raised.
//
// Ports
//   clk    in   1   sole clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   conversion request, sampled only while idle
//   bin    in  16   binary value to convert
//   busy   out  1   high while a conversion is running
//   done   out  1   one-cycle pulse whenever digit is updated
//   err    out  1   last accepted bin was out of range
//   digit  out 16   packed BCD {thousands, hundreds, tens, units}
// ---------------------------------------------------------------------------
module bcd_converter #(
    parameter logic [15:0] ERR_CODE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] digit
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] shift_reg;
    logic [15:0] acc;
    logic [4:0]  count;
    logic [15:0] acc_adj;

    // Double-dabble correction: every nibble of 5 or more gets +3 so that
    // the following left shift carries correctly into the next BCD digit.
    // The addition is deliberately nibble-local; no carry crosses nibbles.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Control FSM and datapath. All outputs are registered, so nothing
    // reaches the ports combinationally from start or bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= 16'h0000;
            acc       <= 16'h0000;
            count     <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            digit     <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bin > 16'd9999) begin
                            // Out-of-range values never enter CONV; the
                            // error code is published straight away.
                            digit <= ERR_CODE;
                            err   <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            shift_reg <= bin;
                            acc       <= 16'h0000;
                            count     <= 5'd0;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                            state     <= CONV;
                        end
                    end
                end
                CONV: begin
                    shift_reg <= {shift_reg[14:0], 1'b0};
                    acc       <= {acc_adj[14:0], shift_reg[15]};
                    count     <= count + 5'd1;
                    // count==15 means this edge performs the 16th iteration,
                    // so the freshly shifted accumulator is the final result.
                    if (count == 5'd15) begin
                        digit <= {acc_adj[14:0], shift_reg[15]};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
